conv_stream_feeder: RTL

//  Producer side of the CONV input interface: answers the layer's ifm_read/wgt_read pulses from two sync-read SRAMs.

---
 rtl/conv_pkg.sv | 40 ++++
 rtl/pad_scan_counter.sv | 64 ++++++
 rtl/conv_stream_feeder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the CONV input-stream feeder.
// The localparams P and KK describe the default layer geometry.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WGT,
        IFM,
        DONE
    } feed_state_e;

    localparam int DEF_IFM_SIZE    = 27;
    localparam int DEF_KERNEL_SIZE = 5;
    localparam int DEF_PAD         = 2;
    localparam int P               = DEF_IFM_SIZE + 2 * DEF_PAD;
    localparam int KK              = DEF_KERNEL_SIZE * DEF_KERNEL_SIZE;

    function automatic int padded_side(input int size, input int pad);
        return size + 2 * pad;
    endfunction

    function automatic int kernel_area(input int k);
        return k * k;
    endfunction

    // Never returns zero, so a count of one still gets a 1-bit register.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int ifm_aw(input int ci, input int size);
        return safe_clog2(ci * size * size);
    endfunction

    function automatic int wgt_aw(input int co, input int ci, input int k);
        return safe_clog2(co * ci * k * k);
    endfunction

endpackage

// File: rtl/pad_scan_counter.sv
// Raster row/col scan over the padded map, with pad-region decode and a
// running interior address that advances only on interior cells.
module pad_scan_counter
    import conv_pkg::*;
#(
    parameter int IFM_SIZE = 27,
    parameter int PAD      = 2,
    parameter int AW       = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          adv,
    output logic          is_pad,
    output logic          last,
    output logic [AW-1:0] addr
);

    localparam int SIDE = padded_side(IFM_SIZE, PAD);
    localparam int CW   = safe_clog2(SIDE);

    localparam logic [CW-1:0] LAST_IDX = CW'(SIDE - 1);
    localparam logic [CW-1:0] LO       = CW'(PAD);
    localparam logic [CW-1:0] HI       = CW'(PAD + IFM_SIZE);

    logic [CW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [AW-1:0] addr_q;
    logic          row_pad;
    logic          col_pad;

    always_comb begin
        row_pad = (row_q < LO) || (row_q >= HI);
        col_pad = (col_q < LO) || (col_q >= HI);
        is_pad  = row_pad || col_pad;
        last    = (row_q == LAST_IDX) && (col_q == LAST_IDX);
        addr    = addr_q;
    end

    // Interior cells are contiguous in raster order, so the SRAM address is
    // a plain count of interior cells visited; channels follow back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else if (clr) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else if (adv) begin
            if (!is_pad) begin
                addr_q <= addr_q + 1'b1;
            end
            if (col_q == LAST_IDX) begin
                col_q <= '0;
                row_q <= (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_stream_feeder.sv
// Producer side of the CONV input interface: serves wgt_read/ifm_read pulses
// from two sync-read SRAMs and injects the zero pad border in-stream.
module conv_stream_feeder
    import conv_pkg::*;
#(
    parameter int IFM_WIDTH    = 16,
    parameter int WEIGHT_WIDTH = 16,
    parameter int IFM_SIZE     = 27,
    parameter int KERNEL_SIZE  = 5,
    parameter int PAD          = 2,
    parameter int CI           = 3,
    parameter int CO           = 8,
    parameter int IFM_AW       = ifm_aw(CI, IFM_SIZE),
    parameter int WGT_AW       = wgt_aw(CO, CI, KERNEL_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    go,
    input  logic                    ifm_read,
    input  logic                    wgt_read,
    input  logic                    end_conv,
    output logic                    ifm_ren,
    output logic [IFM_AW-1:0]       ifm_addr,
    input  logic [IFM_WIDTH-1:0]    ifm_rdata,
    output logic                    wgt_ren,
    output logic [WGT_AW-1:0]       wgt_addr,
    input  logic [WEIGHT_WIDTH-1:0] wgt_rdata,
    output logic                    start_conv,
    output logic                    in_valid,
    output logic [IFM_WIDTH-1:0]    ifm,
    output logic [WEIGHT_WIDTH-1:0] wgt,
    output logic                    busy,
    output logic                    feed_done,
    output logic                    proto_err
);

    localparam int KSQ = kernel_area(KERNEL_SIZE);
    localparam int KW  = safe_clog2(KSQ);
    localparam int CIW = safe_clog2(CI);
    localparam int COW = safe_clog2(CO);

    localparam logic [KW-1:0]  K_LAST  = KW'(KSQ - 1);
    localparam logic [CIW-1:0] CI_LAST = CIW'(CI - 1);
    localparam logic [COW-1:0] CO_LAST = COW'(CO - 1);

    feed_state_e state_q;
    feed_state_e state_d;

    logic [KW-1:0]     k_q;
    logic [CIW-1:0]    ci_q;
    logic [COW-1:0]    co_q;
    logic [WGT_AW-1:0] wgt_addr_q;

    logic              both_read;
    logic              wgt_fire;
    logic              ifm_fire;
    logic              violation;
    logic              chan_end;
    logic              layer_end;
    logic              scan_clr;
    logic              scan_is_pad;
    logic              scan_last;
    logic [IFM_AW-1:0] scan_addr;

    logic              in_valid_q;
    logic              pad_q;
    logic              wgt_vld_q;
    logic              proto_err_q;

    pad_scan_counter #(
        .IFM_SIZE (IFM_SIZE),
        .PAD      (PAD),
        .AW       (IFM_AW)
    ) u_scan (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (scan_clr),
        .adv    (ifm_fire),
        .is_pad (scan_is_pad),
        .last   (scan_last),
        .addr   (scan_addr)
    );

    // A collision of both read pulses is served by neither side.
    always_comb begin
        both_read = ifm_read && wgt_read;
        wgt_fire  = wgt_read && !both_read && (state_q == WGT);
        ifm_fire  = ifm_read && !both_read && (state_q == IFM);
        violation = both_read
                  || (ifm_read && (state_q != IFM))
                  || (wgt_read && (state_q != WGT))
                  || (end_conv && (state_q != DONE));
        chan_end  = ifm_fire && scan_last;
        layer_end = chan_end && (ci_q == CI_LAST) && (co_q == CO_LAST);
        scan_clr  = (state_q == IDLE) || (chan_end && (ci_q == CI_LAST));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (go) state_d = START;
            START:   state_d = WGT;
            WGT:     if (wgt_fire && (k_q == K_LAST)) state_d = IFM;
            IFM:     if (chan_end) state_d = layer_end ? DONE : WGT;
            DONE:    if (end_conv) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments only, so every
    // flop samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q        <= '0;
            ci_q       <= '0;
            co_q       <= '0;
            wgt_addr_q <= '0;
        end else if (state_q == IDLE) begin
            k_q        <= '0;
            ci_q       <= '0;
            co_q       <= '0;
            wgt_addr_q <= '0;
        end else begin
            // Weight blocks are stored in (co, ci) scan order, so the address
            // simply runs on across blocks.
            if (wgt_fire) begin
                wgt_addr_q <= wgt_addr_q + 1'b1;
                k_q        <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
            end
            if (chan_end) begin
                if (ci_q == CI_LAST) begin
                    ci_q <= '0;
                    co_q <= (co_q == CO_LAST) ? '0 : co_q + 1'b1;
                end else begin
                    ci_q <= ci_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_valid_q  <= 1'b0;
            pad_q       <= 1'b0;
            wgt_vld_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            in_valid_q  <= ifm_fire;
            pad_q       <= ifm_fire && scan_is_pad;
            wgt_vld_q   <= wgt_fire;
            proto_err_q <= proto_err_q || violation;
        end
    end

    assign ifm_ren    = ifm_fire && !scan_is_pad;
    assign ifm_addr   = scan_addr;
    assign wgt_ren    = wgt_fire;
    assign wgt_addr   = wgt_addr_q;
    assign start_conv = (state_q == START);
    assign busy       = (state_q != IDLE);
    assign feed_done  = (state_q == DONE);
    assign in_valid   = in_valid_q;
    assign ifm        = (in_valid_q && !pad_q) ? ifm_rdata : '0;
    assign wgt        = wgt_vld_q ? wgt_rdata : '0;
    assign proto_err  = proto_err_q;

endmodule
